// File: rtl/sasc_brg_frac.sv
// Fractional baud-rate generator for the SASC shift engines: emits an
// oversample enable and a bit-rate enable from a run-time int+frac divisor.
module sasc_brg_frac #(
  parameter int CNT_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 4,
  parameter int OSR_W    = 4,
  parameter int DIV_INIT = 260
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              div_ld,
  input  logic [CNT_W-1:0]  div_in,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic              sync_clr,
  output logic              sio_ce_x,
  output logic              sio_ce,
  output logic [OSR_W-1:0]  phase,
  output logic              ld_pend
);

  logic [CNT_W-1:0]  div_act;
  logic [CNT_W-1:0]  div_sh;
  logic [FRAC_W-1:0] frac_act;
  logic [FRAC_W-1:0] frac_sh;
  logic [CNT_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [OSR_W-1:0]  osr_cnt;

  logic              term;
  logic              apply;
  logic              osr_last;
  logic [CNT_W:0]    limit;
  logic [FRAC_W:0]   acc_sum;
  logic [CNT_W-1:0]  div_nxt;
  logic [FRAC_W-1:0] frac_nxt;

  // Limit is one bit wider than the divisor so all-ones plus stretch cannot wrap.
  assign limit    = {1'b0, div_act} + {{CNT_W{1'b0}}, ext};
  assign term     = en & ~sync_clr & (cnt == limit);
  assign osr_last = (osr_cnt == OSR_W'(OSR - 1));
  assign acc_sum  = {1'b0, acc} + {1'b0, frac_act};

  // A load lands on a period boundary, a realign, or immediately while stopped;
  // a strobe in the same cycle bypasses the shadow.
  assign apply    = (div_ld | ld_pend) & (term | sync_clr | ~en);
  assign div_nxt  = div_ld ? div_in  : div_sh;
  assign frac_nxt = div_ld ? frac_in : frac_sh;

  assign phase = osr_cnt;

  // Divisor shadow/active registers, period and phase counters, output pulses.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      div_act  <= CNT_W'(DIV_INIT);
      div_sh   <= CNT_W'(DIV_INIT);
      frac_act <= '0;
      frac_sh  <= '0;
      cnt      <= '0;
      acc      <= '0;
      ext      <= 1'b0;
      osr_cnt  <= '0;
      ld_pend  <= 1'b0;
      sio_ce_x <= 1'b0;
      sio_ce   <= 1'b0;
    end else begin
      if (div_ld) begin
        div_sh  <= div_in;
        frac_sh <= frac_in;
      end
      if (apply) begin
        div_act  <= div_nxt;
        frac_act <= frac_nxt;
      end
      ld_pend <= (ld_pend | div_ld) & ~apply;

      if (sync_clr) begin
        cnt     <= '0;
        acc     <= '0;
        ext     <= 1'b0;
        osr_cnt <= '0;
      end else if (term) begin
        cnt     <= '0;
        osr_cnt <= osr_last ? '0 : osr_cnt + OSR_W'(1);
        // A fresh divisor restarts the fractional sequence from zero.
        if (apply) begin
          acc <= '0;
          ext <= 1'b0;
        end else begin
          acc <= acc_sum[FRAC_W-1:0];
          ext <= acc_sum[FRAC_W];
        end
      end else if (en) begin
        cnt <= cnt + {{CNT_W{1'b0}}, 1'b1};
      end else if (apply) begin
        acc <= '0;
        ext <= 1'b0;
      end

      sio_ce_x <= term;
      sio_ce   <= term & osr_last;
    end
  end

endmodule

// File: tb/tb_sasc_brg_frac.sv
// Directed self-checking bench for sasc_brg_frac; a narrow second instance
// exercises the full-scale divisor without a 2^16-cycle run.
module tb_sasc_brg_frac;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, en, div_ld, sync_clr;
  logic [15:0] div_in;
  logic [3:0]  frac_in;
  logic        sio_ce_x, sio_ce, ld_pend;
  logic [3:0]  phase;

  logic        arst2_n, en2, div_ld2, sync_clr2;
  logic [7:0]  div_in2;
  logic [3:0]  frac_in2;
  logic        sio_ce_x2, sio_ce2, ld_pend2;
  logic [3:0]  phase2;

  int checks = 0;
  int errors = 0;

  sasc_brg_frac dut (
    .clk(clk), .arst_n(arst_n), .en(en), .div_ld(div_ld), .div_in(div_in),
    .frac_in(frac_in), .sync_clr(sync_clr), .sio_ce_x(sio_ce_x),
    .sio_ce(sio_ce), .phase(phase), .ld_pend(ld_pend)
  );

  sasc_brg_frac #(.CNT_W(8), .FRAC_W(4), .OSR(4), .OSR_W(4), .DIV_INIT(3)) dut2 (
    .clk(clk), .arst_n(arst2_n), .en(en2), .div_ld(div_ld2), .div_in(div_in2),
    .frac_in(frac_in2), .sync_clr(sync_clr2), .sio_ce_x(sio_ce_x2),
    .sio_ce(sio_ce2), .phase(phase2), .ld_pend(ld_pend2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the next sio_ce_x pulse; returns the step count, -1 on timeout.
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sio_ce_x && n < 70000);
    if (!sio_ce_x) n = -1;
  endtask

  task automatic wait_pulse2(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sio_ce_x2 && n < 2000);
    if (!sio_ce_x2) n = -1;
  endtask

  // Load while stopped, realign, then run: next pulse comes after d+1 steps.
  task automatic load_clr(input logic [15:0] d, input logic [3:0] f);
    en = 1'b0; div_ld = 1'b1; div_in = d; frac_in = f;
    step();
    div_ld = 1'b0; sync_clr = 1'b1;
    step();
    sync_clr = 1'b0; en = 1'b1;
  endtask

  initial begin
    int n, sum, nx, nce;
    arst_n = 1'b0; en = 1'b1; div_ld = 1'b0; sync_clr = 1'b0;
    div_in = 16'd0; frac_in = 4'd0;
    arst2_n = 1'b0; en2 = 1'b0; div_ld2 = 1'b0; sync_clr2 = 1'b0;
    div_in2 = 8'd0; frac_in2 = 4'd0;

    // Reset defaults
    repeat (3) step();
    check("rst_x", sio_ce_x, 0);
    check("rst_ce", sio_ce, 0);
    check("rst_phase", phase, 0);
    check("rst_pend", ld_pend, 0);
    arst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wait_pulse(n);
      check("def_period", n, 261);
      check("def_ce", sio_ce, (i % 4 == 0) ? 1 : 0);
      check("def_phase", phase, i % 4);
    end

    // Fractional rate 19 + 8/16
    load_clr(16'd19, 4'd8);
    wait_pulse(n);
    check("frac_first", n, 20);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      wait_pulse(n);
      sum += n;
      if (i == 0) check("frac_p0", n, 20);
      if (i == 1) check("frac_p1", n, 21);
    end
    check("frac_span", sum, 328);

    // Boundary load mid-period
    load_clr(16'd99, 4'd0);
    wait_pulse(n);
    check("bnd_base", n, 100);
    repeat (30) step();
    div_ld = 1'b1; div_in = 16'd9;
    step();
    div_ld = 1'b0;
    check("bnd_pend_set", ld_pend, 1);
    wait_pulse(n);
    check("bnd_cur", n + 31, 100);
    check("bnd_pend_clr", ld_pend, 0);
    wait_pulse(n);
    check("bnd_new0", n, 10);
    wait_pulse(n);
    check("bnd_new1", n, 10);

    // Load coincident with the terminal cycle
    repeat (9) step();
    div_ld = 1'b1; div_in = 16'd4;
    step();
    div_ld = 1'b0;
    check("coin_pulse", sio_ce_x, 1);
    check("coin_pend", ld_pend, 0);
    wait_pulse(n);
    check("coin_new", n, 5);
    check("coin_pend2", ld_pend, 0);

    // Realign at cnt=37, phase=2
    load_clr(16'd99, 4'd0);
    wait_pulse(n);
    wait_pulse(n);
    check("rl_phase_pre", phase, 2);
    repeat (37) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("rl_nopulse", sio_ce_x, 0);
    check("rl_phase0", phase, 0);
    for (int i = 1; i <= 4; i++) begin
      wait_pulse(n);
      check("rl_period", n, 100);
      check("rl_ce", sio_ce, (i == 4) ? 1 : 0);
    end

    // sync_clr on the would-be terminal cycle suppresses the pulse
    load_clr(16'd9, 4'd0);
    wait_pulse(n);
    repeat (9) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("sclr_sup", sio_ce_x, 0);
    wait_pulse(n);
    check("sclr_next", n, 10);

    // Enable freeze mid-period
    load_clr(16'd99, 4'd0);
    wait_pulse(n);
    repeat (40) step();
    en = 1'b0;
    nx = 0;
    repeat (50) begin
      step();
      if (sio_ce_x || sio_ce) nx++;
    end
    check("frz_out", nx, 0);
    en = 1'b1;
    wait_pulse(n);
    check("frz_resume", n, 60);

    // Divide by one
    load_clr(16'd0, 4'd0);
    nx = 0; nce = 0;
    repeat (8) begin
      step();
      if (sio_ce_x) nx++;
      if (sio_ce) nce++;
    end
    check("div1_x", nx, 8);
    check("div1_ce", nce, 2);

    // Reset mid-operation with a pending load
    load_clr(16'd99, 4'd0);
    repeat (20) step();
    div_ld = 1'b1; div_in = 16'd9;
    step();
    div_ld = 1'b0;
    check("mrst_pend_pre", ld_pend, 1);
    repeat (5) step();
    arst_n = 1'b0;
    step();
    check("mrst_pend", ld_pend, 0);
    check("mrst_phase", phase, 0);
    check("mrst_x", sio_ce_x, 0);
    arst_n = 1'b1;
    wait_pulse(n);
    check("mrst_p0", n, 261);
    wait_pulse(n);
    check("mrst_p1", n, 261);

    // Full-scale divisor on the 8-bit instance: 2^8, 2^8, then 2^8+1 on carry
    arst2_n = 1'b1;
    div_ld2 = 1'b1; div_in2 = 8'hFF; frac_in2 = 4'hF;
    step();
    div_ld2 = 1'b0; sync_clr2 = 1'b1;
    step();
    sync_clr2 = 1'b0; en2 = 1'b1;
    wait_pulse2(n);
    check("max_p0", n, 256);
    wait_pulse2(n);
    check("max_p1", n, 256);
    wait_pulse2(n);
    check("max_p2", n, 257);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
